opcode_sequencer: RTL
=====================

OPCODE_SEQUENCER -- requirements
Module: opcode_sequencer

Interface
REQ-001 SHALL have parameter PROG_DEPTH, default 16, giving the number of 16-bit program slots (power of two, at least 2).
REQ-002 SHALL have parameter OUT_WIDTH, default 8, giving the number of output bits assembled per pixel word.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, exactly as decided: ports clk and rst_n.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 load_valid  input  1  program word offered on load_data.
REQ-007 load_data  input  16  opcode to append to the program buffer.
REQ-008 load_ready  output  1  buffer can accept a word this cycle.
REQ-009 clear  input  1  empties the program buffer (acted on in IDLE only).
REQ-010 start  input  1  begin one pass of the stored program.
REQ-011 busy  output  1  a program pass is in progress.
REQ-012 done  output  1  one-cycle pulse that marks the end of a pass.
REQ-013 opcode  output  16  opcode issued to the core array.
REQ-014 execute  output  1  opcode is valid this cycle.
REQ-015 output_bit  input  1  serial result bit returned by the core array.
REQ-016 pixel_valid  output  1  one-cycle strobe that marks pixel_data as valid.
REQ-017 pixel_data  output  OUT_WIDTH  assembled output word.

Function
REQ-018 States SHALL be IDLE, RUN and DRAIN. IDLE goes to RUN on start. RUN goes to DRAIN after the last slot is issued. DRAIN goes to IDLE after one cycle.
REQ-019 A load handshake SHALL complete when load_valid and load_ready are both high on a clock edge; the word is written at index len, and len increments by 1.
REQ-020 load_ready SHALL equal (state == IDLE) and (len < PROG_DEPTH).
REQ-021 clear in IDLE SHALL set len to 0; clear SHALL take priority over a simultaneous load or start, and SHALL be ignored outside IDLE.
REQ-022 When start is sampled in IDLE at edge t with len > 0: execute SHALL be 1 with opcode = mem[k] in cycle t+1+k, for k = 0 .. len-1, with no gaps.
REQ-023 With len = 0, start SHALL skip RUN: the block enters DRAIN for one cycle, done pulses, and execute stays 0.
REQ-024 busy SHALL be 1 in the RUN and DRAIN states; done SHALL be 1 only in the DRAIN cycle.
REQ-025 start SHALL be ignored while busy.
REQ-026 In every cycle without an issue, execute SHALL be 0 and opcode SHALL be 16'h0000.
REQ-027 An issued opcode with opcode[15:14] = 2'b11 and opcode[4] = 1 is an output opcode; output_bit SHALL be sampled in the cycle after that opcode is issued. The last slot's sample falls in the DRAIN cycle.
REQ-028 Sampled bits SHALL fill pixel_data LSB first. After OUT_WIDTH samples, pixel_valid SHALL pulse in the next cycle, pixel_data SHALL hold the word until the next completion, and the sample count SHALL return to 0.
REQ-029 start SHALL discard any partially assembled pixel word, setting the sample count to 0.
REQ-030 The program buffer contents SHALL persist across passes until clear or reset.

Reset
REQ-031 While rst_n = 0, the following SHALL hold: state = IDLE, len = 0, execute = 0, opcode = 0, busy = 0, done = 0, pixel_valid = 0, pixel_data = 0, sample count = 0, and load_ready = 1 (because state is IDLE and len is 0).
REQ-032 Reset asserted during RUN SHALL abort the pass with no done pulse; program buffer contents need not be preserved.

Structure
REQ-033 The following SHALL be defined as constants in the shared package gpu_pkg: the opcode misc-class field position (bits [15:14]) and value (2'b11), and the output-flag bit index (4).
REQ-034 The program storage SHALL be a sub-module named opcode_mem: PROG_DEPTH x 16 bits, one synchronous write port and one read port. No reset is required on its storage.

Verification
REQ-035 Load 3 words 16'hC010, 16'h0001, 16'hC010, then start at edge t -> execute high in cycles t+1 .. t+3 with those opcodes in order, done high in cycle t+4, busy low from cycle t+5.
REQ-036 Load 16 words -> load_ready is 0 after the 16th handshake, and a 17th load_valid does not change len.
REQ-037 With OUT_WIDTH = 8, load 8 x 16'hC010 and drive output_bit with the pattern 1,0,1,1,0,0,1,0 on the sample cycles -> pixel_valid pulses once with pixel_data = 8'h4D.
REQ-038 clear and start asserted together in IDLE -> len = 0, no execute; a following start gives a done pulse with execute never high.
REQ-039 start re-asserted during RUN -> ignored, exactly len issues occur; rst_n driven low mid-RUN -> all outputs 0 immediately and no done pulse.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared opcode field definitions and sequencer state encoding.
package gpu_pkg;

  localparam int unsigned OPC_W        = 16;
  localparam int unsigned MISC_HI      = 15;
  localparam int unsigned MISC_LO      = 14;
  localparam logic [1:0]  MISC_CLASS   = 2'b11;
  localparam int unsigned OUT_FLAG_BIT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

endpackage

// File: rtl/opcode_mem.sv
// Program store: one synchronous write port, one combinational read port, no reset.
module opcode_mem
  import gpu_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [OPC_W-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [OPC_W-1:0]  rdata_o
);

  logic [OPC_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/opcode_sequencer.sv
// Replays a loaded opcode program to the core array and assembles the
// serial result bits of output opcodes into pixel words.
module opcode_sequencer
  import gpu_pkg::*;
#(
  parameter int unsigned PROG_DEPTH = 16,
  parameter int unsigned OUT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_valid,
  input  logic [OPC_W-1:0]     load_data,
  output logic                 load_ready,
  input  logic                 clear,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [OPC_W-1:0]     opcode,
  output logic                 execute,
  input  logic                 output_bit,
  output logic                 pixel_valid,
  output logic [OUT_WIDTH-1:0] pixel_data
);

  localparam int unsigned IDX_W = $clog2(PROG_DEPTH);
  localparam int unsigned LEN_W = IDX_W + 1;
  localparam int unsigned CNT_W = $clog2(OUT_WIDTH + 1);

  seq_state_e           state_q, state_d;
  logic [LEN_W-1:0]     len_q, len_d, idx_q, idx_d;
  logic [OPC_W-1:0]     opcode_q, opcode_d, rd_data;
  logic                 execute_q, execute_d, busy_q, busy_d;
  logic                 done_q, done_d, ready_q, ready_d;
  logic                 sample_q, sample_d, pv_q, pv_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d, pix_q, pix_d;
  logic                 load_fire_c, start_acc_c;

  // ready_q is only ever set in IDLE, so it also qualifies the state
  assign load_fire_c = load_valid && ready_q && !clear;
  assign start_acc_c = (state_q == ST_IDLE) && start && !clear;

  opcode_mem #(
    .DEPTH  (PROG_DEPTH),
    .ADDR_W (IDX_W)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (load_fire_c),
    .waddr_i (len_q[IDX_W-1:0]),
    .wdata_i (load_data),
    .raddr_i (idx_q[IDX_W-1:0]),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_acc_c) state_d = (len_q == '0) ? ST_DRAIN : ST_RUN;
      ST_RUN:   if (idx_q == len_q) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    len_d     = len_q;
    idx_d     = idx_q;
    execute_d = 1'b0;
    opcode_d  = '0;
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (clear)            len_d = '0;
        else if (load_fire_c) len_d = len_q + LEN_W'(1);
      end
      ST_RUN: begin
        if (idx_q != len_q) begin
          execute_d = 1'b1;
          opcode_d  = rd_data;
          idx_d     = idx_q + LEN_W'(1);
        end
      end
      default: ;
    endcase
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DRAIN);
    ready_d = (state_d == ST_IDLE) && (len_d < LEN_W'(PROG_DEPTH));
  end

  // Result bit of an output opcode arrives one cycle after it is issued
  always_comb begin
    sample_d = execute_q && (opcode_q[MISC_HI:MISC_LO] == MISC_CLASS) && opcode_q[OUT_FLAG_BIT];
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    pix_d    = pix_q;
    pv_d     = 1'b0;
    if (start_acc_c) begin
      cnt_d = '0;
    end else if (sample_q) begin
      acc_d = ((cnt_q == '0) ? '0 : acc_q) | (OUT_WIDTH'(output_bit) << cnt_q);
      if (cnt_q == CNT_W'(OUT_WIDTH - 1)) begin
        pix_d = acc_d;
        pv_d  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= '0;
      idx_q     <= '0;
      opcode_q  <= '0;
      execute_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
      sample_q  <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      pix_q     <= '0;
      pv_q      <= 1'b0;
    end else begin
      len_q     <= len_d;
      idx_q     <= idx_d;
      opcode_q  <= opcode_d;
      execute_q <= execute_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      sample_q  <= sample_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      pix_q     <= pix_d;
      pv_q      <= pv_d;
    end
  end

  assign load_ready  = ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign opcode      = opcode_q;
  assign execute     = execute_q;
  assign pixel_valid = pv_q;
  assign pixel_data  = pix_q;

endmodule
